// File: rtl/wm_embed_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : wm_embed_pipe
//  Purpose  : Three-stage pipelined LL-band watermark embedder/remover.
//             Computes ll1 +/- (ll2 * alpha) >> FRAC with saturation, under
//             valid/ready flow control, and tracks frame boundaries and
//             per-frame saturation counts.
//  Revision : 1.0 - initial release
// ============================================================================
module wm_embed_pipe #(
  parameter int DW        = 16,   // coefficient width
  parameter int AW        = 8,    // alpha width
  parameter int FRAC      = 4,    // fractional bits of alpha
  parameter int FRAME_LEN = 4096, // output transfers per frame
  parameter int CW        = 13    // frame position counter width
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode,
  input  logic [DW-1:0] ll1,
  input  logic [DW-1:0] ll2,
  input  logic [AW-1:0] alpha,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_coef,
  output logic          out_sat,
  output logic          out_last,
  output logic [15:0]   sat_cnt,
  output logic          frame_done
);

  localparam int              PW         = DW + AW;      // full product width
  localparam int              SW         = DW + AW + 1;  // embed sum width
  localparam logic [CW-1:0]   c_LAST_POS = CW'(FRAME_LEN - 1);
  localparam logic [15:0]     c_CNT_MAX  = 16'hFFFF;

  // Stage S1: captured input pair and per-sample controls
  logic          r_s1_valid;
  logic          r_s1_mode;
  logic [DW-1:0] r_s1_ll1;
  logic [DW-1:0] r_s1_ll2;
  logic [AW-1:0] r_s1_alpha;

  // Stage S2: full product, with ll1/mode carried alongside
  logic          r_s2_valid;
  logic          r_s2_mode;
  logic [DW-1:0] r_s2_ll1;
  logic [PW-1:0] r_s2_prod;

  // Stage S3: output registers
  logic          r_out_valid;
  logic [DW-1:0] r_out_coef;
  logic          r_out_sat;

  // Frame tracking
  logic [CW-1:0] r_pos;
  logic [15:0]   r_sat_cnt;
  logic          r_frame_done;

  // Combinational helpers
  logic          w_adv;
  logic          w_out_xfer;
  logic          w_last;
  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_scaled;
  logic [SW-1:0] w_sum;
  logic          w_over;
  logic          w_under;
  logic [DW-1:0] w_diff;
  logic [DW-1:0] w_res_coef;
  logic          w_res_sat;

  // The whole pipeline advances together whenever the output slot is free
  // or being drained; bubbles move through without blocking upstream.
  assign w_adv      = ~r_out_valid | out_ready;
  assign in_ready   = w_adv;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_last     = r_out_valid & (r_pos == c_LAST_POS);

  // Product is exact at DW+AW bits; scaling truncates the fraction.
  assign w_prod   = PW'(r_s1_ll2) * PW'(r_s1_alpha);
  assign w_scaled = r_s2_prod >> FRAC;
  assign w_sum    = SW'(r_s2_ll1) + SW'(w_scaled);
  assign w_over   = |w_sum[SW-1:DW];
  assign w_under  = w_scaled > PW'(r_s2_ll1);
  assign w_diff   = r_s2_ll1 - w_scaled[DW-1:0];

  // Select the saturated embed or remove result for stage S3
  always_comb begin
    w_res_coef = '0;
    w_res_sat  = 1'b0;
    if (!r_s2_mode) begin
      if (w_over) begin
        w_res_coef = '1;
        w_res_sat  = 1'b1;
      end else begin
        w_res_coef = w_sum[DW-1:0];
      end
    end else begin
      if (w_under) begin
        w_res_coef = '0;
        w_res_sat  = 1'b1;
      end else begin
        w_res_coef = w_diff;
      end
    end
  end

  // S1: register the input pair together with its own mode and alpha
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_ll1   <= '0;
      r_s1_ll2   <= '0;
      r_s1_alpha <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode  <= mode;
        r_s1_ll1   <= ll1;
        r_s1_ll2   <= ll2;
        r_s1_alpha <= alpha;
      end
    end
  end

  // S2: register the full-width product; ll1 and mode travel with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_mode  <= 1'b0;
      r_s2_ll1   <= '0;
      r_s2_prod  <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mode <= r_s1_mode;
        r_s2_ll1  <= r_s1_ll1;
        r_s2_prod <= w_prod;
      end
    end
  end

  // S3: load the output registers; they hold while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_coef  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_coef <= w_res_coef;
        r_out_sat  <= w_res_sat;
      end
    end
  end

  // Frame position, end-of-frame pulse and per-frame saturation count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos        <= '0;
      r_frame_done <= 1'b0;
      r_sat_cnt    <= '0;
    end else begin
      r_frame_done <= w_out_xfer & w_last;
      if (w_out_xfer) begin
        r_pos <= w_last ? '0 : r_pos + CW'(1);
      end
      // The clear takes priority; a coincident saturated transfer then
      // starts the new frame's count at one.
      if (r_frame_done) begin
        r_sat_cnt <= (w_out_xfer & r_out_sat) ? 16'd1 : 16'd0;
      end else if (w_out_xfer && r_out_sat && (r_sat_cnt != c_CNT_MAX)) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_coef   = r_out_coef;
  assign out_sat    = r_out_sat;
  assign out_last   = w_last;
  assign sat_cnt    = r_sat_cnt;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_wm_embed_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wm_embed_pipe
//  Purpose  : Self-checking bench for wm_embed_pipe (FRAME_LEN=4 main DUT,
//             FRAME_LEN=1 companion DUT on the same stimulus).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wm_embed_pipe;

  localparam int FL   = 4;
  localparam int FRAC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] ll1 = '0;
  logic [15:0] ll2 = '0;
  logic [7:0]  alpha = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_sat, out_last, frame_done;
  logic [15:0] out_coef, sat_cnt;
  logic        in_ready_1, out_valid_1, out_sat_1, out_last_1, frame_done_1;
  logic [15:0] out_coef_1, sat_cnt_1;

  always #5 clk = ~clk;

  wm_embed_pipe #(.DW(16), .AW(8), .FRAC(FRAC), .FRAME_LEN(FL), .CW(13)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .ll1(ll1), .ll2(ll2), .alpha(alpha),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
    .out_sat(out_sat), .out_last(out_last), .sat_cnt(sat_cnt),
    .frame_done(frame_done));

  wm_embed_pipe #(.DW(16), .AW(8), .FRAC(FRAC), .FRAME_LEN(1), .CW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
    .mode(mode), .ll1(ll1), .ll2(ll2), .alpha(alpha),
    .out_valid(out_valid_1), .out_ready(out_ready), .out_coef(out_coef_1),
    .out_sat(out_sat_1), .out_last(out_last_1), .sat_cnt(sat_cnt_1),
    .frame_done(frame_done_1));

  typedef struct {
    logic        mode;
    logic [15:0] ll1;
    logic [15:0] ll2;
    logic [7:0]  alpha;
    logic [15:0] coef;
    logic        sat;
  } vec_t;

  vec_t        tbl[10];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [16:0] sbq[$];          // expected {sat, coef} in issue order
  int          n_out = 0;       // output transfers since reset
  logic [15:0] m_cnt = '0;      // expected sat_cnt
  logic        m_fd = 1'b0;     // expected frame_done
  logic        prev_xfer1 = 1'b0;
  logic        stalled = 1'b0;
  logic [15:0] snap_coef = '0;
  logic        snap_sat = 1'b0;
  logic        snap_last = 1'b0;
  logic        last_in_xfer = 1'b0;
  int          got_out = 0, got_last = 0, got_fd = 0;

  logic        d_valid = 1'b0, d_mode = 1'b0, d_ready = 1'b0;
  logic [15:0] d_ll1 = '0, d_ll2 = '0;
  logic [7:0]  d_alpha = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the embed/remove rules
  function automatic logic [16:0] ref_res(input logic m, input logic [15:0] a,
                                          input logic [15:0] b, input logic [7:0] al);
    longint sc, s;
    sc = (longint'(b) * longint'(al)) / (longint'(1) << FRAC);
    if (!m) begin
      s = longint'(a) + sc;
      if (s > 65535) return {1'b1, 16'hFFFF};
      return {1'b0, 16'(s)};
    end
    if (sc > longint'(a)) return {1'b1, 16'h0000};
    return {1'b0, 16'(longint'(a) - sc)};
  endfunction

  task automatic clear_model();
    sbq.delete();
    n_out = 0; m_cnt = '0; m_fd = 1'b0; prev_xfer1 = 1'b0; stalled = 1'b0;
  endtask

  // One clock: check at the falling edge, drive, then account transfers
  task automatic step();
    logic        xo, xi, lexp, xs, exp_rdy;
    logic [16:0] e;
    @(negedge clk);
    if (stalled) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_coef", out_coef, snap_coef);
      chk("stall_sat", out_sat, snap_sat);
      chk("stall_last", out_last, snap_last);
    end
    chk("frame_done", frame_done, m_fd);
    chk("sat_cnt", sat_cnt, m_cnt);
    chk("fl1_valid", out_valid_1, out_valid);
    chk("fl1_last", out_last_1, out_valid_1);
    chk("fl1_done", frame_done_1, prev_xfer1);
    if (out_valid) chk("fl1_coef", out_coef_1, out_coef);
    if (frame_done) got_fd++;
    in_valid = d_valid; mode = d_mode; ll1 = d_ll1; ll2 = d_ll2;
    alpha = d_alpha; out_ready = d_ready;
    #1;
    exp_rdy = !out_valid || out_ready;
    chk("in_ready", in_ready, exp_rdy);
    xo = out_valid & out_ready;
    xi = in_valid & in_ready;
    lexp = (n_out % FL) == (FL - 1);
    xs = 1'b0;
    if (out_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious_out", out_valid, 0);
      end else begin
        e = sbq[0];
        chk("out_coef", out_coef, e[15:0]);
        chk("out_sat", out_sat, e[16]);
        chk("out_last", out_last, lexp);
        if (xo) begin
          void'(sbq.pop_front());
          xs = e[16];
        end
      end
    end
    if (m_fd) m_cnt = (xo && xs) ? 16'd1 : 16'd0;
    else if (xo && xs && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_fd = xo && lexp;
    if (xo) begin
      n_out++; got_out++;
      if (out_last) got_last++;
    end
    prev_xfer1 = out_valid_1 & out_ready;
    if (xi) sbq.push_back(ref_res(in_valid ? mode : 1'b0, ll1, ll2, alpha));
    stalled = out_valid & ~out_ready;
    snap_coef = out_coef; snap_sat = out_sat; snap_last = out_last;
    last_in_xfer = xi;
  endtask

  task automatic rand_pair();
    d_mode  = 1'($urandom_range(0, 1));
    d_ll1   = ($urandom_range(0, 3) == 0) ? (16'hFF00 | 16'($urandom_range(0, 255)))
                                          : 16'($urandom);
    d_ll2   = 16'($urandom);
    d_alpha = 8'($urandom);
  endtask

  task automatic drain();
    d_valid = 1'b0; d_ready = 1'b1;
    for (int k = 0; k < 60 && sbq.size() > 0; k++) step();
    chk("drain_left", sbq.size(), 0);
    step(); step();
  endtask

  // Asynchronous reset between clock edges, checked before any edge
  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_last", out_last, 0);
    clear_model();
    d_valid = 1'b0; in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_out, base_last, base_fd, i, cyc;
    vec_t bp[8];
    logic [3:0] pat;
    tbl[0] = '{1'b0, 16'd100,    16'd40,     8'h08, 16'd120,   1'b0};
    tbl[1] = '{1'b0, 16'hFFF0,   16'h0100,   8'h10, 16'hFFFF,  1'b1};
    tbl[2] = '{1'b1, 16'd10,     16'd100,    8'h10, 16'd0,     1'b1};
    tbl[3] = '{1'b1, 16'd500,    16'd50,     8'h20, 16'd400,   1'b0};
    tbl[4] = '{1'b0, 16'd1234,   16'hFFFF,   8'h00, 16'd1234,  1'b0};
    tbl[5] = '{1'b0, 16'd0,      16'hFFFF,   8'hFF, 16'hFFFF,  1'b1};
    tbl[6] = '{1'b0, 16'hFFFE,   16'd1,      8'h10, 16'hFFFF,  1'b0};
    tbl[7] = '{1'b1, 16'd300,    16'd300,    8'h10, 16'd0,     1'b0};
    tbl[8] = '{1'b1, 16'd100,    16'd3,      8'h08, 16'd99,    1'b0};
    tbl[9] = '{1'b1, 16'd299,    16'd300,    8'h10, 16'd0,     1'b1};

    // Reset state
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_coef", out_coef, 0);
    chk("reset_out_sat", out_sat, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_sat_cnt", sat_cnt, 0);
    chk("reset_frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1);

    // Directed vectors, one at a time, with latency check
    for (int v = 0; v < 10; v++) begin
      d_valid = 1'b1; d_ready = 1'b1;
      d_mode = tbl[v].mode; d_ll1 = tbl[v].ll1; d_ll2 = tbl[v].ll2; d_alpha = tbl[v].alpha;
      step();
      d_valid = 1'b0;
      step(); step();
      chk($sformatf("tbl%0d_early", v), out_valid, 0);
      step();
      chk($sformatf("tbl%0d_valid", v), out_valid, 1);
      chk($sformatf("tbl%0d_coef", v), out_coef, tbl[v].coef);
      chk($sformatf("tbl%0d_sat", v), out_sat, tbl[v].sat);
    end
    drain();

    // Backpressure: 8 pairs, out_ready cycling 1-0-0-1
    pat = 4'b1001;
    for (int k = 0; k < 8; k++) begin
      rand_pair();
      bp[k] = '{d_mode, d_ll1, d_ll2, d_alpha, 16'd0, 1'b0};
    end
    base_out = got_out; i = 0; cyc = 0;
    while ((i < 8 || sbq.size() > 0) && cyc < 200) begin
      d_ready = pat[cyc % 4];
      d_valid = (i < 8);
      if (i < 8) begin
        d_mode = bp[i].mode; d_ll1 = bp[i].ll1; d_ll2 = bp[i].ll2; d_alpha = bp[i].alpha;
      end
      step();
      if (stalled) chk("bp_in_ready_hold", in_ready, 0);
      if (last_in_xfer) i++;
      cyc++;
    end
    chk("bp_count", got_out - base_out, 8);
    drain();

    // Frame tracking from a fresh start: 10 continuous pairs
    apply_reset();
    base_last = got_last; base_fd = got_fd;
    d_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rand_pair(); d_valid = 1'b1; step();
    end
    drain();
    chk("frame_last_count", got_last - base_last, 2);
    chk("frame_done_count", got_fd - base_fd, 2);

    // Async reset with three pairs in flight
    d_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_pair(); d_valid = 1'b1; step();
    end
    @(posedge clk); #2;
    chk("inflight_valid", out_valid, 1);
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_idle", out_valid, 0);
    end
    base_last = got_last; base_out = got_out;
    for (int k = 0; k < FL; k++) begin
      rand_pair(); d_valid = 1'b1; step();
    end
    drain();
    chk("post_rst_outs", got_out - base_out, FL);
    chk("post_rst_last", got_last - base_last, 1);

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      rand_pair();
      d_valid = ($urandom_range(0, 3) != 0);
      d_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
    chk("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wm_embed_pipe.md
Name: wm_embed_pipe

Overview:
- Pipelined, parametrised successor to the combinational LL-band embedder. Computes LLNEW = LL1 ± (alpha·LL2) with fixed-point alpha and saturation.
- Streams one coefficient pair per cycle under valid/ready flow control and tracks frame boundaries.
- Sits between the DWT LL-subband buffers (host and watermark) and the inverse-DWT input.

Parameters:
- DW, 16, unsigned width of LL1, LL2 and out_coef.
- AW, 8, unsigned width of alpha; fixed-point with FRAC fractional bits.
- FRAC, 4, fractional bits of alpha; 0x10 = 1.0 at the default.
- FRAME_LEN, 4096, output transfers per frame (LL subband size); must be >= 1.
- CW, 13, width of the frame position counter; must satisfy 2^CW >= FRAME_LEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept the input pair.
- mode  in  1  0 = embed (add), 1 = remove (subtract); sampled per transfer.
- ll1  in  DW  host LL coefficient.
- ll2  in  DW  watermark LL coefficient.
- alpha  in  AW  strength factor; sampled per transfer.
- out_valid  out  1  output coefficient valid.
- out_ready  in  1  downstream accepts the output.
- out_coef  out  DW  saturated result.
- out_sat  out  1  result was clamped.
- out_last  out  1  output is the final coefficient of a frame.
- sat_cnt  out  16  saturated outputs in the current frame.
- frame_done  out  1  one-cycle pulse after the last transfer of a frame.

Behaviour:
- Reset (async, rst_n=0): all valids 0, out_coef 0, out_sat 0, out_last 0, sat_cnt 0, frame_done 0, position counter 0. in_ready is 1 once rst_n is released.
- Pipeline stage S1: register ll1, ll2, alpha and mode on an input transfer (in_valid & in_ready).
- Pipeline stage S2: register prod = (ll2 * alpha), a full DW+AW-bit value, and scaled = prod >> FRAC (truncating). ll1 and mode are carried alongside.
- Pipeline stage S3: compute the result and drive the out_* registers.
  - Embed: sum = ll1 + scaled, at DW+AW+1 bits. If sum > 2^DW-1, out_coef = all ones and out_sat = 1.
  - Remove: if scaled > ll1, out_coef = 0 and out_sat = 1; otherwise out_coef = ll1 - scaled.
- Latency: 3 cycles from input transfer to out_valid when there is no stall. Throughput is 1 pair per cycle.
- Flow control:
  - adv = ~out_valid | out_ready, and in_ready = adv.
  - When adv = 0, every stage holds its contents and valid bits.
  - Bubbles propagate as valid = 0 and do not stall upstream.
  - out_coef, out_sat and out_last must stay stable while out_valid & ~out_ready.
- Frame tracking:
  - pos counts output transfers (out_valid & out_ready).
  - out_last = out_valid & (pos == FRAME_LEN-1).
  - On a transfer with out_last set, pos wraps to 0 and frame_done pulses high on the next cycle.
- sat_cnt:
  - Increments on each output transfer with out_sat = 1, saturating at 0xFFFF.
  - Clears to 0 on the cycle frame_done is high.
  - If a saturated transfer coincides with that clear, the cleared value wins and the new count becomes 1.
- Per-sample mode and alpha: values may change every transfer; each result uses the values captured with its own pair.
- Reset mid-operation: in-flight data is discarded and the position counter restarts at 0. Nothing is emitted after reset until new inputs arrive.
- FRAME_LEN = 1: every output has out_last set.

Test Plan:
- Embed, alpha=0x08, ll1=100, ll2=40 → out_coef=120 three cycles later, out_sat=0.
- Embed overflow, alpha=0x10, ll1=0xFFF0, ll2=0x0100 → out_coef=0xFFFF, out_sat=1, sat_cnt=1.
- Remove underflow, mode=1, alpha=0x10, ll1=10, ll2=100 → out_coef=0, out_sat=1.
- Remove normal, mode=1, alpha=0x20, ll1=500, ll2=50 → out_coef=400.
- Backpressure: stream 8 pairs with out_ready toggling 1-0-0-1 → all 8 results in order, no duplicates or losses, outputs stable during stalls, in_ready=0 while a stall is held.
- Frame: FRAME_LEN=4, 10 continuous pairs → out_last on outputs 4 and 8, frame_done pulses twice, sat_cnt cleared after each pulse.
- Async reset asserted with 3 pairs in flight → out_valid=0 immediately, and the next frame's out_last lands on the FRAME_LEN-th post-reset output.
